seq_multiplier_param: RTL and testbench
=======================================

# seq_multiplier_param

Parametrised sequential shift-add multiplier with integrated datapath (A, B, X registers) and control FSM. Multiplies a latched WIDTH-bit multiplicand S by the WIDTH-bit multiplier held in B. The multiplier runs in unsigned or two's-complement mode, selected per operation. It is the WIDTH-generic successor of the fixed 8-bit lab multiplier and sits between the board switch/button synchronisers and the hex-display drivers.

## Interface
Parameters:
- WIDTH, default 8, operand width; legal range 2..32; product is 2*WIDTH bits in {A,B}.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high; one clock; the polarity and synchronicity are fixed.
- Run  in  1  level start request; already debounced and synchronised.
- ClearA_LoadB  in  1  level; honoured only in IDLE.
- Din  in  WIDTH  switch operand; the B load value, and the S value latched on start.
- Signed_mode  in  1  1 = two's complement, 0 = unsigned; sampled on start.
- Aval  out  WIDTH  A register (product high half).
- Bval  out  WIDTH  B register (multiplier, then product low half).
- X  out  1  sign/extension bit.
- Busy  out  1  high in CLEAR, ADD, SHIFT.
- Done  out  1  high in HOLD.

## Operation
- Internal state: S (WIDTH), mode bit, cnt ($clog2(WIDTH) bits), FSM {IDLE, CLEAR, ADD, SHIFT, HOLD}.
- Reset: FSM←IDLE; A, B, X, S, cnt, mode←0. Reset overrides all other inputs, including during an operation.
- IDLE:
  - Run=1: S←Din, mode←Signed_mode, go to CLEAR. ClearA_LoadB is ignored in the same cycle.
  - Else, ClearA_LoadB=1: A←0, X←0, B←Din.
- CLEAR: A←0, X←0, cnt←0; go to ADD.
- ADD, with B[0]=1:
  - signed: {X,A}←sext(A)±sext(S), (WIDTH+1)-bit arithmetic. Subtract when cnt==WIDTH-1; add otherwise.
  - unsigned: {X,A}←{0,A}+{0,S}; X is the carry-out.
- ADD, with B[0]=0: X←A[WIDTH-1] if signed, else X←0; A unchanged.
- After ADD: go to SHIFT.
- SHIFT: {X,A,B}←{X',X,A,B[WIDTH-1:1]}. X'=X if signed, 0 if unsigned.
- After SHIFT: if cnt==WIDTH-1, go to HOLD; else cnt←cnt+1 and go to ADD.
- HOLD: registers frozen; ClearA_LoadB ignored. Run=0 → IDLE. Run held → remain in HOLD indefinitely.
- Result: {A,B} = product. In signed mode X equals the product sign.
- Din and Signed_mode changes during Busy have no effect.

## Timing
- The edge at which IDLE samples Run=1 is edge 0.
- CLEAR spans edge 0 to edge 1. The WIDTH ADD/SHIFT pairs occupy edges 1 to 2*WIDTH+1.
- HOLD is entered at edge 2*WIDTH+1. Done first reads high after edge 2*WIDTH+1 (17 cycles for WIDTH=8).
- Busy rises after edge 0 and falls when Done rises. Busy and Done are never both high.
- A new operation needs Run low for at least one cycle in HOLD, then a Run high sample in IDLE.
- Reset asserted at any edge: after that edge Busy=0, Done=0, A=B=X=0.
- Outputs are registered-state decodes; there is no combinational path from inputs to outputs.

## Configuration
- SEQ_MULT_SIGNED_EN defined: signed mode is implemented as specified above.
- SEQ_MULT_SIGNED_EN undefined: the Signed_mode port is kept but ignored; mode is forced to 0 (unsigned only). No subtract logic and no sign replication are synthesised. Timing is unchanged.

## Test plan
- WIDTH=8, unsigned: load B=0x07, Din=0x03, Run → Done after exactly 17 cycles; Aval=0x00, Bval=0x15, X=0.
- WIDTH=8, signed: B=0xFE, Din=0x03 → Aval=0xFF, Bval=0xFA, X=1. Also B=0x80, Din=0x80 → Aval=0x40, Bval=0x00, X=0.
- WIDTH=8, unsigned: B=0xFF, Din=0xFF → Aval=0xFE, Bval=0x01, X=0. The same operands in signed mode → Aval=0x00, Bval=0x01, X=0.
- Run held high through HOLD for 10 cycles → Done stays 1 and registers are stable; ClearA_LoadB pulsed in HOLD has no effect. Release Run → IDLE next cycle.
- Reset asserted 5 cycles after start → Busy=0, Done=0, A=B=X=0 next cycle; no Done pulse follows. Run and ClearA_LoadB asserted together in IDLE → B is not reloaded.
- WIDTH=4, signed: B=0xF, Din=0x7 → Done after 9 cycles; {A,B}=0xF9, X=1. Repeat with SEQ_MULT_SIGNED_EN undefined → {A,B}=0x69, X=0.

Source files
------------

// File: rtl/seq_multiplier_param.sv
// WIDTH-generic shift-add multiplier (A, B, X datapath plus control FSM); product lands in {A,B}.
// Define SEQ_MULT_SIGNED_EN to build two's-complement support; otherwise Signed_mode is ignored.
module seq_multiplier_param #(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Run,
    input  logic             ClearA_LoadB,
    input  logic [WIDTH-1:0] Din,
    input  logic             Signed_mode,
    output logic [WIDTH-1:0] Aval,
    output logic [WIDTH-1:0] Bval,
    output logic             X,
    output logic             Busy,
    output logic             Done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ADD,
        S_SHIFT,
        S_HOLD
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             x_q, x_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   sum;
    logic             signed_op;

`ifdef SEQ_MULT_SIGNED_EN
    logic mode_q, mode_d;
    assign signed_op = mode_q;
`else
    // Unsigned-only build: the port stays for pin compatibility but drives nothing.
    logic unused_mode;
    assign unused_mode = Signed_mode;
    assign signed_op   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        sum     = '0;
`ifdef SEQ_MULT_SIGNED_EN
        mode_d  = mode_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (Run) begin
                    s_d     = Din;
`ifdef SEQ_MULT_SIGNED_EN
                    mode_d  = Signed_mode;
`endif
                    state_d = S_CLEAR;
                end else if (ClearA_LoadB) begin
                    a_d = '0;
                    x_d = 1'b0;
                    b_d = Din;
                end
            end
            S_CLEAR: begin
                a_d     = '0;
                x_d     = 1'b0;
                cnt_d   = '0;
                state_d = S_ADD;
            end
            S_ADD: begin
                if (b_q[0]) begin
`ifdef SEQ_MULT_SIGNED_EN
                    // The last partial product carries negative weight for a signed multiplier.
                    if (mode_q) begin
                        if (cnt_q == CNT_LAST)
                            sum = {a_q[WIDTH-1], a_q} - {s_q[WIDTH-1], s_q};
                        else
                            sum = {a_q[WIDTH-1], a_q} + {s_q[WIDTH-1], s_q};
                    end else begin
                        sum = {1'b0, a_q} + {1'b0, s_q};
                    end
`else
                    sum = {1'b0, a_q} + {1'b0, s_q};
`endif
                    {x_d, a_d} = sum;
                end else begin
                    x_d = signed_op & a_q[WIDTH-1];
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                x_d = signed_op & x_q;
                a_d = {x_q, a_q[WIDTH-1:1]};
                b_d = {a_q[0], b_q[WIDTH-1:1]};
                if (cnt_q == CNT_LAST) begin
                    state_d = S_HOLD;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_ADD;
                end
            end
            S_HOLD: begin
                if (!Run)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            x_q     <= 1'b0;
            cnt_q   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
`ifdef SEQ_MULT_SIGNED_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign Aval = a_q;
    assign Bval = b_q;
    assign X    = x_q;
    assign Busy = (state_q == S_CLEAR) || (state_q == S_ADD) || (state_q == S_SHIFT);
    assign Done = (state_q == S_HOLD);

endmodule

// File: tb/tb_seq_multiplier_param.sv
// Self-checking bench for seq_multiplier_param: WIDTH=8 and WIDTH=4 instances against an arithmetic product model.
module tb_seq_multiplier_param;

`ifdef SEQ_MULT_SIGNED_EN
    localparam bit SG_EN = 1'b1;
`else
    localparam bit SG_EN = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset;
    logic       Run8, Clb8, Sg8, X8, Busy8, Done8;
    logic [7:0] Din8, Aval8, Bval8;
    logic       Run4, Clb4, Sg4, X4, Busy4, Done4;
    logic [3:0] Din4, Aval4, Bval4;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    seq_multiplier_param #(.WIDTH(8)) u8 (
        .Clk(Clk), .Reset(Reset), .Run(Run8), .ClearA_LoadB(Clb8), .Din(Din8),
        .Signed_mode(Sg8), .Aval(Aval8), .Bval(Bval8), .X(X8), .Busy(Busy8), .Done(Done8)
    );

    seq_multiplier_param #(.WIDTH(4)) u4 (
        .Clk(Clk), .Reset(Reset), .Run(Run4), .ClearA_LoadB(Clb4), .Din(Din4),
        .Signed_mode(Sg4), .Aval(Aval4), .Bval(Bval4), .X(X4), .Busy(Busy4), .Done(Done4)
    );

    // Returns {x, product[63:0]}: exact integer product truncated to 2*w bits, x = its sign when signed.
    function automatic logic [64:0] ref_mul(input int w, input logic [31:0] s, input logic [31:0] b,
                                            input bit sg);
        longint     sv, bv, p;
        logic [63:0] pm;
        bit         xb;
        sv = longint'(s);
        bv = longint'(b);
        if (sg && s[w-1]) sv = sv - (longint'(1) << w);
        if (sg && b[w-1]) bv = bv - (longint'(1) << w);
        p  = sv * bv;
        pm = 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
        xb = sg ? pm[2*w-1] : 1'b0;
        return {xb, pm};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Called just after the edge that sampled Run=1; follows the operation to Done and checks it.
    task automatic finish8(input logic [64:0] r);
        int n = 0;
        Din8 = 8'($urandom);
        Sg8  = 1'($urandom);
        while (Done8 !== 1'b1 && n < 60) begin
            chk("busy8", 64'(Busy8), 64'd1);
            tick();
            n++;
        end
        chk("latency8", 64'(n), 64'd17);
        chk("busy_at_done8", 64'(Busy8), 64'd0);
        chk("a8", 64'(Aval8), 64'(r[15:8]));
        chk("b8", 64'(Bval8), 64'(r[7:0]));
        chk("x8", 64'(X8), 64'(r[64]));
    endtask

    task automatic op8(input logic [7:0] b, input logic [7:0] s, input bit sg);
        Clb8 = 1'b1; Din8 = b; tick();
        Clb8 = 1'b0; Din8 = s; Sg8 = sg; Run8 = 1'b1; tick();
        finish8(ref_mul(8, 32'(s), 32'(b), sg && SG_EN));
    endtask

    task automatic release8();
        Run8 = 1'b0;
        tick();
        chk("idle_done8", 64'(Done8), 64'd0);
        chk("idle_busy8", 64'(Busy8), 64'd0);
    endtask

    task automatic op4(input logic [3:0] b, input logic [3:0] s, input bit sg);
        logic [64:0] r;
        int n = 0;
        r = ref_mul(4, 32'(s), 32'(b), sg && SG_EN);
        Clb4 = 1'b1; Din4 = b; tick();
        Clb4 = 1'b0; Din4 = s; Sg4 = sg; Run4 = 1'b1; tick();
        Din4 = 4'($urandom);
        Sg4  = 1'($urandom);
        while (Done4 !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("latency4", 64'(n), 64'd9);
        chk("ab4", 64'({Aval4, Bval4}), 64'(r[7:0]));
        chk("x4", 64'(X4), 64'(r[64]));
        Run4 = 1'b0;
        tick();
        chk("idle_done4", 64'(Done4), 64'd0);
    endtask

    initial begin
        logic [7:0] ha, hb;
        logic       hx;
        bit         saw_done;

        Reset = 1'b1;
        Run8 = 1'b0; Clb8 = 1'b0; Din8 = '0; Sg8 = 1'b0;
        Run4 = 1'b0; Clb4 = 1'b0; Din4 = '0; Sg4 = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        chk("rst_a8", 64'(Aval8), 64'd0);
        chk("rst_b8", 64'(Bval8), 64'd0);
        chk("rst_x8", 64'(X8), 64'd0);
        chk("rst_busy8", 64'(Busy8), 64'd0);
        chk("rst_done8", 64'(Done8), 64'd0);
        chk("rst_ab4", 64'({Aval4, Bval4, X4, Busy4, Done4}), 64'd0);

        // Directed operand pairs with hand-computed products.
        op8(8'h07, 8'h03, 1'b0);
        chk("u7x3", 64'({X8, Aval8, Bval8}), 64'h00015);
        release8();
        op8(8'hFE, 8'h03, 1'b1);
        chk("s_m2x3", 64'({X8, Aval8, Bval8}), SG_EN ? 64'h1FFFA : 64'h002FA);
        release8();
        op8(8'h80, 8'h80, 1'b1);
        chk("s_m128sq", 64'({X8, Aval8, Bval8}), 64'h04000);
        release8();
        op8(8'hFF, 8'hFF, 1'b0);
        chk("u_ffsq", 64'({X8, Aval8, Bval8}), 64'h0FE01);
        release8();
        op8(8'hFF, 8'hFF, 1'b1);
        chk("s_m1sq", 64'({X8, Aval8, Bval8}), SG_EN ? 64'h00001 : 64'h0FE01);
        release8();

        // Run held through HOLD; a ClearA_LoadB pulse there must be ignored.
        op8(8'hD3, 8'h0B, 1'b1);
        ha = Aval8; hb = Bval8; hx = X8;
        for (int i = 0; i < 10; i++) begin
            Clb8 = (i == 3);
            Din8 = 8'h55;
            tick();
            chk("hold_done", 64'(Done8), 64'd1);
            chk("hold_regs", 64'({X8, Aval8, Bval8}), 64'({hx, ha, hb}));
        end
        Clb8 = 1'b0;
        release8();
        chk("idle_keep", 64'({X8, Aval8, Bval8}), 64'({hx, ha, hb}));

        // Reset mid-operation, then make sure no Done follows.
        Clb8 = 1'b1; Din8 = 8'h5A; tick();
        Clb8 = 1'b0; Din8 = 8'h33; Run8 = 1'b1; tick();
        for (int i = 0; i < 4; i++) tick();
        Reset = 1'b1; Run8 = 1'b0;
        tick();
        Reset = 1'b0;
        chk("midrst_busy", 64'(Busy8), 64'd0);
        chk("midrst_done", 64'(Done8), 64'd0);
        chk("midrst_regs", 64'({X8, Aval8, Bval8}), 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (Done8 === 1'b1 || Busy8 === 1'b1) saw_done = 1'b1;
        end
        chk("midrst_quiet", 64'(saw_done), 64'd0);

        // Run and ClearA_LoadB together in IDLE: the start wins and B keeps 0x05.
        Clb8 = 1'b1; Din8 = 8'h05; tick();
        Din8 = 8'h0A; Sg8 = 1'b0; Run8 = 1'b1; Clb8 = 1'b1; tick();
        Clb8 = 1'b0;
        finish8(ref_mul(8, 32'h0A, 32'h05, 1'b0));
        chk("runclb_prod", 64'({Aval8, Bval8}), 64'h0032);
        release8();

        for (int k = 0; k < 24; k++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom));
            release8();
        end

        op4(4'hF, 4'h7, 1'b1);
        chk("w4_m1x7", 64'({X4, Aval4, Bval4}), SG_EN ? 64'h1F9 : 64'h069);
        op4(4'h8, 4'h8, 1'b1);
        op4(4'hF, 4'hF, 1'b0);
        for (int k = 0; k < 8; k++) op4(4'($urandom), 4'($urandom), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
